parallel_serial_tx: RTL and testbench

Parallel-to-serial transmitter on the clk_32f domain, sitting directly upstream of serial_parallel_c on the serial lane. Accepts 8-bit bytes through a valid/ready handshake into a one-entry holding buffer and shifts them out MSB first, one bit per clk_32f cycle. After reset it emits a training burst of comma bytes (0xBC) so the downstream converter can align. Whenever no data byte is buffered at a byte boundary, it inserts an idle comma.

---
 rtl/parallel_serial_tx.sv | 113 +++++++++++
 tb/tb_parallel_serial_tx.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/parallel_serial_tx.sv
// parallel_serial_tx
//   Parallel-to-serial transmitter for the clk_32f serial lane. Bytes arrive through a
//   valid/ready handshake into a one-entry holding buffer and are shifted out MSB first,
//   one bit per clock. After reset a burst of COMMA_COUNT comma bytes is sent so the
//   downstream converter can align; afterwards a comma is inserted at every byte boundary
//   where no data byte is buffered.
//
// Ports
//   clk_32f    in   bit clock, rising edge
//   reset      in   synchronous, active-high
//   valid_in   in   data_in holds a byte to transfer
//   data_in    in   [7:0] parallel byte
//   ready_out  out  a byte can be accepted this cycle
//   data_out   out  serial bit (shift register MSB)
//   tx_active  out  high once training has finished
//   byte_start out  first bit of a byte is on data_out

module parallel_serial_tx #(
   parameter logic [7:0]  COMMA       = 8'hBC,
   parameter int unsigned COMMA_COUNT = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       valid_in,
   input  logic [7:0] data_in,
   output logic       ready_out,
   output logic       data_out,
   output logic       tx_active,
   output logic       byte_start
);

   typedef enum logic [0:0] {StTrain, StRun} state_e;

   state_e     state_q, state_d;
   logic [7:0] shreg_q, shreg_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic [3:0] comma_cnt_q, comma_cnt_d;
   logic [7:0] buf_data_q, buf_data_d;
   logic       buf_full_q, buf_full_d;

   logic boundary;
   logic accept;

   assign boundary   = (bitcnt_q == 3'd7);
   // At a RUN boundary the buffer drains into the shift register on this same edge,
   // so a new byte can be taken even while the buffer is full.
   assign ready_out  = !buf_full_q || (state_q == StRun && boundary);
   assign accept     = valid_in && ready_out;
   assign data_out   = shreg_q[7];
   assign tx_active  = (state_q == StRun);
   assign byte_start = (bitcnt_q == 3'd0);

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bitcnt_d    = bitcnt_q;
      comma_cnt_d = comma_cnt_q;
      buf_data_d  = buf_data_q;
      buf_full_d  = buf_full_q;

      if (boundary) begin
         bitcnt_d = 3'd0;
         unique case (state_q)
            StTrain: begin
               // Training never consumes the buffer; a byte taken now waits for RUN.
               shreg_d = COMMA;
               if (comma_cnt_q == 4'(COMMA_COUNT - 1)) begin
                  state_d = StRun;
               end else begin
                  comma_cnt_d = comma_cnt_q + 4'd1;
               end
            end
            StRun: begin
               if (buf_full_q) begin
                  shreg_d    = buf_data_q;
                  buf_full_d = 1'b0;
               end else begin
                  shreg_d = COMMA;
               end
            end
            default: ;
         endcase
      end else begin
         shreg_d  = {shreg_q[6:0], 1'b0};
         bitcnt_d = bitcnt_q + 3'd1;
      end

      // Placed after the drain so a same-cycle refill keeps the buffer full.
      if (accept) begin
         buf_data_d = data_in;
         buf_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk_32f) begin
      if (reset) begin
         state_q     <= StTrain;
         shreg_q     <= COMMA;
         bitcnt_q    <= 3'd0;
         comma_cnt_q <= 4'd0;
         buf_data_q  <= 8'd0;
         buf_full_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bitcnt_q    <= bitcnt_d;
         comma_cnt_q <= comma_cnt_d;
         buf_data_q  <= buf_data_d;
         buf_full_q  <= buf_full_d;
      end
   end

endmodule

// File: tb/tb_parallel_serial_tx.sv
// Directed bench for parallel_serial_tx. Inputs change 1 time unit after the rising edge,
// outputs are checked at the same point, so "cycle k" is the k-th clock period after the
// last reset edge (bit counter at k mod 8 while no reset intervenes).

module tb_parallel_serial_tx;

   logic       clk_32f = 1'b0;
   logic       reset;
   logic       valid_in;
   logic [7:0] data_in;
   logic       ready_out;
   logic       data_out;
   logic       tx_active;
   logic       byte_start;

   int errors = 0;
   int checks = 0;

   logic [7:0] cm  = 8'hBC;
   logic [7:0] a5  = 8'hA5;
   logic [7:0] b7e = 8'h7E;

   parallel_serial_tx #(
      .COMMA       (8'hBC),
      .COMMA_COUNT (4)
   ) dut (
      .clk_32f    (clk_32f),
      .reset      (reset),
      .valid_in   (valid_in),
      .data_in    (data_in),
      .ready_out  (ready_out),
      .data_out   (data_out),
      .tx_active  (tx_active),
      .byte_start (byte_start)
   );

   always #5 clk_32f = ~clk_32f;

   task automatic tick();
      @(posedge clk_32f);
      #1;
   endtask

   task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] b;
      int         n;
      logic       exp_rdy;
      logic       exp_bit;

      reset    = 1'b0;
      valid_in = 1'b0;
      data_in  = 8'h00;

      // Two reset cycles, then idle training plus commas.
      reset = 1'b1;
      tick();
      do_reset();
      chk("rst_data_out", 0, data_out, 1'b1);
      chk("rst_ready", 0, ready_out, 1'b1);
      chk("rst_tx_active", 0, tx_active, 1'b0);
      chk("rst_byte_start", 0, byte_start, 1'b1);

      for (int c = 0; c < 64; c++) begin
         chk("idle_bit", c, data_out, cm[7 - (c % 8)]);
         chk("idle_byte_start", c, byte_start, (c % 8) == 0);
         chk("idle_tx_active", c, tx_active, c >= 32);
         chk("idle_ready", c, ready_out, 1'b1);
         tick();
      end

      // Single 0xA5 accepted at bit counter 6 (cycle 70).
      for (int c = 64; c < 88; c++) begin
         valid_in = (c == 70);
         data_in  = (c == 70) ? 8'hA5 : 8'h00;
         chk("a5_ready", c, ready_out, 1'b1);
         if (c >= 72 && c < 80) chk("a5_bit", c, data_out, a5[7 - (c - 72)]);
         else                   chk("a5_comma", c, data_out, cm[7 - (c % 8)]);
         tick();
      end
      valid_in = 1'b0;

      // Back-to-back 0x01, 0x02, 0x03 with valid held until all three are taken.
      n = 0;
      for (int c = 88; c < 128; c++) begin
         valid_in = (n < 3);
         data_in  = 8'(n + 1);
         exp_rdy  = (c == 88) || (c == 95) || (c == 103) || (c >= 111);
         chk("b2b_ready", c, ready_out, exp_rdy);
         if (c >= 96 && c < 120) begin
            b       = 8'((c - 96) / 8 + 1);
            exp_bit = b[7 - ((c - 96) % 8)];
         end else begin
            exp_bit = cm[7 - (c % 8)];
         end
         chk("b2b_bit", c, data_out, exp_bit);
         tick();
         if (n < 3 && exp_rdy) n++;
      end
      valid_in = 1'b0;

      // 0x7E offered during training (cycle 5); it is held until the first RUN boundary
      // (cycle 39) and serialized from cycle 40.
      do_reset();
      for (int c = 0; c < 56; c++) begin
         valid_in = (c == 5);
         data_in  = (c == 5) ? 8'h7E : 8'h00;
         chk("train_ready", c, ready_out, (c <= 5) || (c >= 39));
         chk("train_tx_active", c, tx_active, c >= 32);
         if (c >= 40 && c < 48) chk("train_7e_bit", c, data_out, b7e[7 - (c - 40)]);
         else                   chk("train_comma", c, data_out, cm[7 - (c % 8)]);
         tick();
      end

      // Fill the buffer at cycle 56, then reset at bit counter 4 (cycle 60).
      valid_in = 1'b1;
      data_in  = 8'h55;
      chk("mid_accept_ready", 56, ready_out, 1'b1);
      tick();
      valid_in = 1'b0;
      chk("mid_buf_full", 57, ready_out, 1'b0);
      tick();
      tick();
      tick();
      chk("mid_bytestart", 60, byte_start, 1'b0);
      do_reset();
      chk("mid_rst_data_out", 0, data_out, 1'b1);
      chk("mid_rst_tx_active", 0, tx_active, 1'b0);
      for (int c = 0; c < 48; c++) begin
         chk("mid_ready", c, ready_out, 1'b1);
         chk("mid_comma", c, data_out, cm[7 - (c % 8)]);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
